// File: rtl/expipe_pkg.sv
// Shared execution-pipeline types for the common data bus: widths, source count
// and the result record carried from each requester into the broadcast register.
package expipe_pkg;

  localparam int XLEN           = 64;
  localparam int ROB_IDX_LEN    = 5;
  localparam int ROB_EXCEPT_LEN = 4;
  localparam int CDB_N_SRC      = 4;

  typedef struct packed {
    logic [ROB_IDX_LEN-1:0]    rob_idx;
    logic [XLEN-1:0]           value;
    logic                      except_raised;
    logic [ROB_EXCEPT_LEN-1:0] except_code;
  } cdb_data_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin arbiter: priority encoder on a request vector rotated by ptr_q.
// With CDB_FIXED_PRIO_EN defined it collapses to a plain lowest-index priority encoder.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic [N-1:0]                          req,
  input  logic                                  advance,
  input  logic                                  flush,
  output logic [N-1:0]                          grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  winner,
  output logic                                  valid
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] enc_in;
  logic [W-1:0] enc_idx;

  always_comb begin
    valid   = 1'b0;
    enc_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (enc_in[i]) begin
        valid   = 1'b1;
        enc_idx = W'(i);
      end
    end
  end

`ifdef CDB_FIXED_PRIO_EN
  logic unused_fixed;
  assign unused_fixed = ^{clk_i, rst_n_i, advance, flush};
  assign enc_in       = req;
  assign winner       = enc_idx;
`else
  logic [W-1:0] ptr_q;
  logic [W:0]   rot_sum;
  logic [W:0]   win_sum;

  // Sums stay one bit wider so the modulo-N wrap also works for non-power-of-2 N.
  always_comb begin
    enc_in  = '0;
    rot_sum = '0;
    for (int k = 0; k < N; k++) begin
      rot_sum = {1'b0, ptr_q} + (W+1)'(k);
      if (rot_sum >= (W+1)'(N)) rot_sum = rot_sum - (W+1)'(N);
      enc_in[k] = req[rot_sum[W-1:0]];
    end
  end

  always_comb begin
    win_sum = {1'b0, ptr_q} + {1'b0, enc_idx};
    if (win_sum >= (W+1)'(N)) win_sum = win_sum - (W+1)'(N);
    winner = win_sum[W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else if (flush) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (winner == W'(N - 1)) ? '0 : winner + W'(1);
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (valid) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one requester per cycle into a single broadcast
// register that stalls on ROB backpressure. CDB_FIXED_PRIO_EN selects fixed priority.
module cdb_arbiter #(
  parameter int N_SRC          = expipe_pkg::CDB_N_SRC,
  parameter int XLEN           = expipe_pkg::XLEN,
  parameter int ROB_IDX_LEN    = expipe_pkg::ROB_IDX_LEN,
  parameter int ROB_EXCEPT_LEN = expipe_pkg::ROB_EXCEPT_LEN
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 flush_i,
  input  logic [N_SRC-1:0]                     valid_i,
  output logic [N_SRC-1:0]                     ready_o,
  input  logic [N_SRC-1:0][ROB_IDX_LEN-1:0]    idx_i,
  input  logic [N_SRC-1:0][XLEN-1:0]           data_i,
  input  logic [N_SRC-1:0]                     except_raised_i,
  input  logic [N_SRC-1:0][ROB_EXCEPT_LEN-1:0] except_code_i,
  input  logic                                 rob_ready_i,
  output logic                                 cdb_valid_o,
  output logic [ROB_IDX_LEN-1:0]               cdb_idx_o,
  output logic [XLEN-1:0]                      cdb_data_o,
  output logic                                 cdb_except_raised_o,
  output logic [ROB_EXCEPT_LEN-1:0]            cdb_except_o
);

  import expipe_pkg::*;

  localparam int W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] arb_grant;
  logic [W-1:0]     arb_winner;
  logic             arb_valid;
  logic             can_load;
  logic             load_en;
  logic             transfer;
  logic             cdb_valid_q;
  cdb_data_t        cdb_q;
  cdb_data_t        sel;

  assign can_load = !cdb_valid_q || rob_ready_i;
  assign load_en  = can_load && !flush_i;
  assign ready_o  = load_en ? arb_grant : '0;
  assign transfer = load_en && arb_valid;

  rr_arbiter #(.N(N_SRC)) u_rr_arbiter (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req     (valid_i),
    .advance (transfer),
    .flush   (flush_i),
    .grant   (arb_grant),
    .winner  (arb_winner),
    .valid   (arb_valid)
  );

  always_comb begin
    sel.rob_idx       = idx_i[arb_winner];
    sel.value         = data_i[arb_winner];
    sel.except_raised = except_raised_i[arb_winner];
    sel.except_code   = except_code_i[arb_winner];
  end

  // Data fields are left untouched on flush and drain; only the valid bit matters then.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
    end else if (flush_i) begin
      cdb_valid_q <= 1'b0;
    end else if (can_load) begin
      cdb_valid_q <= arb_valid;
      if (arb_valid) cdb_q <= sel;
    end
  end

  assign cdb_valid_o         = cdb_valid_q;
  assign cdb_idx_o           = cdb_q.rob_idx;
  assign cdb_data_o          = cdb_q.value;
  assign cdb_except_raised_o = cdb_q.except_raised;
  assign cdb_except_o        = cdb_q.except_code;

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    $onehot0(ready_o));

  a_valid_known: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !$isunknown(cdb_valid_o));

  for (genvar s = 0; s < N_SRC; s++) begin : g_src_stable
    a_fields_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      (valid_i[s] && !ready_o[s] && !flush_i) |=>
      (!valid_i[s] || ($stable(idx_i[s]) && $stable(data_i[s]) &&
                       $stable(except_raised_i[s]) && $stable(except_code_i[s]))));
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios then random traffic,
// all checked against a queue-free behavioural model of grant order and broadcast.
module tb_cdb_arbiter;
  import expipe_pkg::*;

  localparam int N = CDB_N_SRC;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic rob_ready;
  logic [N-1:0] valid;
  logic [N-1:0] ready_o;
  cdb_data_t src [N];
  logic [N-1:0][ROB_IDX_LEN-1:0]    idx_w;
  logic [N-1:0][XLEN-1:0]           data_w;
  logic [N-1:0]                     exr_w;
  logic [N-1:0][ROB_EXCEPT_LEN-1:0] exc_w;
  logic                      cdb_valid_o;
  logic [ROB_IDX_LEN-1:0]    cdb_idx_o;
  logic [XLEN-1:0]           cdb_data_o;
  logic                      cdb_except_raised_o;
  logic [ROB_EXCEPT_LEN-1:0] cdb_except_o;

  int tests = 0;
  int fails = 0;

  logic      m_valid;
  cdb_data_t m_bc;
  int        m_ptr;

  always #5 clk = ~clk;

  always_comb begin
    for (int s = 0; s < N; s++) begin
      idx_w[s]  = src[s].rob_idx;
      data_w[s] = src[s].value;
      exr_w[s]  = src[s].except_raised;
      exc_w[s]  = src[s].except_code;
    end
  end

  cdb_arbiter dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .flush_i             (flush),
    .valid_i             (valid),
    .ready_o             (ready_o),
    .idx_i               (idx_w),
    .data_i              (data_w),
    .except_raised_i     (exr_w),
    .except_code_i       (exc_w),
    .rob_ready_i         (rob_ready),
    .cdb_valid_o         (cdb_valid_o),
    .cdb_idx_o           (cdb_idx_o),
    .cdb_data_o          (cdb_data_o),
    .cdb_except_raised_o (cdb_except_raised_o),
    .cdb_except_o        (cdb_except_o)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner is the first valid source scanning from the pointer with wrap; nobody
  // wins while flushing or while the ROB is refusing a pending broadcast.
  function automatic logic [N-1:0] expected_grant();
    logic [N-1:0] g;
    int s;
    g = '0;
    if (!flush && !(m_valid && !rob_ready)) begin
      for (int k = 0; k < N; k++) begin
        s = (m_ptr + k) % N;
        if (valid[s] && g == '0) g[s] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic load_src(input int s, input logic [ROB_IDX_LEN-1:0] idx,
                          input logic [XLEN-1:0] data, input logic exr,
                          input logic [ROB_EXCEPT_LEN-1:0] exc);
    src[s].rob_idx       = idx;
    src[s].value         = data;
    src[s].except_raised = exr;
    src[s].except_code   = exc;
    valid[s]             = 1'b1;
  endtask

  task automatic load_random(input int s);
    load_src(s, ROB_IDX_LEN'($urandom), {$urandom, $urandom},
             $urandom_range(0, 3) == 0, ROB_EXCEPT_LEN'($urandom));
  endtask

  task automatic peek_ready(input string tag, input logic [N-1:0] exp);
    #2;
    check_output(tag, 64'(ready_o), 64'(exp));
  endtask

  // Entered just after a rising edge with inputs already driven; returns just after the next one.
  task automatic apply_stimulus(input string tag);
    logic [N-1:0] g;
    int w;
    #2;
    g = expected_grant();
    check_output({tag, " ready_o"}, 64'(ready_o), 64'(g));
    @(posedge clk);
    #1;
    if (flush) begin
      m_valid = 1'b0;
      m_ptr   = 0;
    end else if (!m_valid || rob_ready) begin
      if (g != '0) begin
        w = 0;
        for (int s = 0; s < N; s++) if (g[s]) w = s;
        m_bc     = src[w];
        m_valid  = 1'b1;
`ifdef CDB_FIXED_PRIO_EN
        m_ptr    = 0;
`else
        m_ptr    = (w + 1) % N;
`endif
        valid[w] = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    check_output({tag, " cdb_valid"}, 64'(cdb_valid_o), 64'(m_valid));
    if (m_valid) begin
      check_output({tag, " cdb_idx"}, 64'(cdb_idx_o), 64'(m_bc.rob_idx));
      check_output({tag, " cdb_data"}, 64'(cdb_data_o), 64'(m_bc.value));
      check_output({tag, " cdb_exr"}, 64'(cdb_except_raised_o), 64'(m_bc.except_raised));
      check_output({tag, " cdb_exc"}, 64'(cdb_except_o), 64'(m_bc.except_code));
    end
  endtask

  initial begin
    logic [N-1:0] want;
    rst_n     = 1'b0;
    flush     = 1'b0;
    rob_ready = 1'b1;
    valid     = '0;
    for (int s = 0; s < N; s++) src[s] = '0;
    m_valid = 1'b0;
    m_bc    = '0;
    m_ptr   = 0;

    #12;
    check_output("reset ready_o", 64'(ready_o), 64'h0);
    check_output("reset cdb_valid", 64'(cdb_valid_o), 64'h0);
    check_output("reset cdb_idx", 64'(cdb_idx_o), 64'h0);
    check_output("reset cdb_data", 64'(cdb_data_o), 64'h0);
    check_output("reset cdb_exr", 64'(cdb_except_raised_o), 64'h0);
    check_output("reset cdb_exc", 64'(cdb_except_o), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      apply_stimulus("idle");
      check_output("idle cdb_data", 64'(cdb_data_o), 64'h0);
      check_output("idle cdb_idx", 64'(cdb_idx_o), 64'h0);
    end

    load_src(2, 5'd5, 64'hDEADBEEF, 1'b0, '0);
    peek_ready("single grant", 4'b0100);
    apply_stimulus("single");
    check_output("single cdb_valid", 64'(cdb_valid_o), 64'h1);
    check_output("single cdb_idx", 64'(cdb_idx_o), 64'd5);
    check_output("single cdb_data", 64'(cdb_data_o), 64'hDEADBEEF);
    apply_stimulus("drain");
    check_output("drain cdb_valid", 64'(cdb_valid_o), 64'h0);

    flush = 1'b1;
    apply_stimulus("ptr clear");
    flush = 1'b0;
    for (int s = 0; s < N; s++) load_random(s);
    for (int i = 0; i < 5; i++) begin
`ifdef CDB_FIXED_PRIO_EN
      want = 4'b0001;
`else
      want = 4'b0001 << (i % N);
`endif
      peek_ready("rr order", want);
      apply_stimulus("rr");
      for (int s = 0; s < N; s++) if (!valid[s]) load_random(s);
    end

    valid[2]  = 1'b0;
    valid[3]  = 1'b0;
    rob_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      peek_ready("hold grant", 4'b0000);
      apply_stimulus("hold");
    end
    rob_ready = 1'b1;
`ifdef CDB_FIXED_PRIO_EN
    peek_ready("resume grant", 4'b0001);
`else
    peek_ready("resume grant", 4'b0010);
`endif
    apply_stimulus("resume");
    valid = '0;
    apply_stimulus("drain2");
    check_output("drain2 cdb_valid", 64'(cdb_valid_o), 64'h0);

    load_src(3, 5'd9, 64'h1234, 1'b1, 4'h2);
    peek_ready("except grant", 4'b1000);
    apply_stimulus("except");
    check_output("except cdb_exr", 64'(cdb_except_raised_o), 64'h1);
    check_output("except cdb_exc", 64'(cdb_except_o), 64'h2);

    for (int s = 0; s < N; s++) load_random(s);
    flush = 1'b1;
    peek_ready("flush grant", 4'b0000);
    apply_stimulus("flush");
    check_output("flush cdb_valid", 64'(cdb_valid_o), 64'h0);
    flush = 1'b0;
    peek_ready("post flush grant", 4'b0001);
    apply_stimulus("post flush");

    for (int i = 0; i < 400; i++) begin
      rob_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      for (int s = 0; s < N; s++) begin
        if (!valid[s] && $urandom_range(0, 1) == 1) load_random(s);
      end
      apply_stimulus("random");
    end
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
